// File: rtl/mem_io_unit.sv
// -----------------------------------------------------------------------------
// mem_io_unit
//   Memory-side end of the LC-3 datapath bus. Holds MAR and MDR (both loaded
//   from the shared BUS), runs one read or write per MIO_EN request over a
//   req/ack handshake, reports completion on R and drives MDR toward the BUS
//   tri-state gate under GateMDR. A sticky err flag records transactions that
//   were abandoned because memory never acknowledged.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   bus_in            current BUS value
//   LDMAR / LDMDR     load MAR (any state) / MDR (IDLE only) from bus_in
//   MIO_EN, R_W       request a transaction; R_W=1 write, 0 read
//   GateMDR           put MDR on mdr_bus_out, mirrored on mdr_bus_oe
//   err_clr           clear the sticky timeout flag
//   mdr_bus_out/_oe   MDR toward BUS (0 when not gated) and its enable
//   R                 transaction complete (registered, DONE state)
//   mem_req/we/addr/wdata  request to memory; we/addr/wdata 0 when idle
//   mem_rdata/mem_ack read data and acknowledge from memory
//   err               sticky timeout flag
//   dbg_state         current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: mem_req is high for every cycle the unit is in ACCESS, with
// mem_we/mem_addr/mem_wdata held stable throughout. A transfer completes on the
// first rising edge where mem_req and mem_ack are both high; mem_ack at any
// other time is ignored. mem_rdata must be valid on that edge.
// -----------------------------------------------------------------------------
module mem_io_unit #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              LDMAR,
    input  logic              LDMDR,
    input  logic              MIO_EN,
    input  logic              R_W,
    input  logic              GateMDR,
    input  logic              err_clr,
    output logic [DATA_W-1:0] mdr_bus_out,
    output logic              mdr_bus_oe,
    output logic              R,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              timeout;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        timeout = 1'b0;

        // MAR loads in any state; the in-flight address lives in addr_q.
        if (LDMAR) begin
            mar_d = bus_in[ADDR_W-1:0];
        end

        case (state_q)
            IDLE: begin
                if (LDMDR) begin
                    mdr_d = bus_in;
                end
                // Latch the pre-edge MAR/MDR, even if they load on this edge.
                if (MIO_EN) begin
                    addr_d  = mar_q;
                    we_d    = R_W;
                    wdata_d = mdr_q;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the last permitted cycle still completes normally.
                if (mem_ack) begin
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Holding MIO_EN keeps us here so it cannot re-issue.
                if (!MIO_EN) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set wins over clear on the same edge.
        err_d = err_clr ? 1'b0 : err_q;
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req     = (state_q == ACCESS);
    assign mem_we      = mem_req & we_q;
    assign mem_addr    = mem_req ? addr_q : '0;
    assign mem_wdata   = mem_req ? wdata_q : '0;
    assign R           = (state_q == DONE);
    assign err         = err_q;
    assign mdr_bus_out = GateMDR ? mdr_q : '0;
    assign mdr_bus_oe  = GateMDR;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_io_unit.sv
module tb_mem_io_unit;

  localparam int TMO = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic        LDMAR, LDMDR, MIO_EN, R_W, GateMDR, err_clr;
  logic [15:0] mdr_bus_out;
  logic        mdr_bus_oe, R, mem_req, mem_we, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_io_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .LDMAR(LDMAR), .LDMDR(LDMDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .GateMDR(GateMDR), .err_clr(err_clr),
    .mdr_bus_out(mdr_bus_out), .mdr_bus_oe(mdr_bus_oe), .R(R),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- memory responder ----------------
  // resp_mode: 0 never ack, 1 ack on the ack_after-th request cycle, 2 ack always
  int          resp_mode = 0;
  int          ack_after = 1;
  int          req_seen = 0;
  int          last_req_len = 0;
  int          txn_count = 0;
  logic [15:0] last_addr = '0, last_wdata = '0;
  logic        last_we = 1'b0;

  always @(negedge clk) begin
    if (mem_req) begin
      req_seen++;
      last_addr  = mem_addr;
      last_we    = mem_we;
      last_wdata = mem_wdata;
    end else if (req_seen > 0) begin
      last_req_len = req_seen;
      txn_count++;
      req_seen = 0;
    end
    mem_ack = (resp_mode == 2) || (resp_mode == 1 && mem_req && req_seen == ack_after);
  end

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for a request, 1 memory busy, 2 finished
  int          m_phase;
  int          m_age;
  logic [15:0] m_mar, m_mdr, m_addr, m_wdata;
  logic        m_we, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_mar = 0; m_mdr = 0;
      m_addr = 0; m_wdata = 0; m_we = 0; m_err = 0;
    end else begin
      int          old_phase;
      logic [15:0] old_mar, old_mdr;
      bit          gave_up;
      old_phase = m_phase;
      old_mar   = m_mar;
      old_mdr   = m_mdr;
      gave_up   = 0;
      if (old_phase == 0 && MIO_EN) begin
        m_addr = old_mar; m_we = R_W; m_wdata = old_mdr; m_age = 0; m_phase = 1;
      end else if (old_phase == 1) begin
        if (mem_ack) begin
          if (!m_we) m_mdr = mem_rdata;
          m_phase = 2;
        end else begin
          m_age = m_age + 1;
          if (m_age >= TMO) begin gave_up = 1; m_phase = 2; end
        end
      end else if (old_phase == 2 && !MIO_EN) begin
        m_phase = 0;
      end
      if (LDMAR) m_mar = bus_in;
      if (LDMDR && old_phase == 0) m_mdr = bus_in;
      if (err_clr) m_err = 0;
      if (gave_up) m_err = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_req", mem_req, m_phase == 1);
      check("cyc_r", R, m_phase == 2);
      check("cyc_err", err, m_err);
      check("cyc_bus", mdr_bus_out, GateMDR ? m_mdr : 16'h0);
      check("cyc_oe", mdr_bus_oe, GateMDR);
      if (m_phase == 1) begin
        check("cyc_addr", mem_addr, m_addr);
        check("cyc_we", mem_we, m_we);
        check("cyc_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; LDMAR = 1; tick(); LDMAR = 0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; LDMDR = 1; tick(); LDMDR = 0;
  endtask

  task automatic wait_r(input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (R) got = 1;
    end
    check(name, got, 1);
  endtask

  task automatic peek_mdr(input string name, input logic [15:0] exp);
    GateMDR = 1; #1;
    check(name, mdr_bus_out, exp);
    GateMDR = 0; #1;
  endtask

  // ---------------- directed tests ----------------
  int base;

  initial begin
    rst_n = 0; bus_in = 0; LDMAR = 0; LDMDR = 0; MIO_EN = 0; R_W = 0;
    GateMDR = 0; err_clr = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_r", R, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    cmp_en = 1;
    peek_mdr("rst_mdr", 16'h0);

    // 1: read, ack on the third request cycle
    load_mar(16'h3000);
    resp_mode = 1; ack_after = 3; mem_rdata = 16'hBEEF;
    MIO_EN = 1; R_W = 0;
    tick();
    wait_r("t1_done");
    check("t1_req_len", last_req_len, 3);
    check("t1_addr", last_addr, 16'h3000);
    check("t1_we", last_we, 0);
    peek_mdr("t1_mdr", 16'hBEEF);
    MIO_EN = 0; tick();

    // 2: write, ack on first request cycle
    load_mdr(16'h1234);
    load_mar(16'h4000);
    ack_after = 1;
    MIO_EN = 1; R_W = 1;
    tick();
    check("t2_req", mem_req, 1);
    tick();
    check("t2_r_two_edges", R, 1);
    check("t2_addr", last_addr, 16'h4000);
    check("t2_we", last_we, 1);
    check("t2_wdata", last_wdata, 16'h1234);
    MIO_EN = 0; tick();

    // 3: timeout, then clear; then timeout with clear held (set wins)
    resp_mode = 0;
    MIO_EN = 1; R_W = 0;
    tick();
    wait_r("t3_done");
    check("t3_req_len", last_req_len, TMO);
    check("t3_err", err, 1);
    peek_mdr("t3_mdr", 16'h1234);
    MIO_EN = 0; tick();
    err_clr = 1; tick(); err_clr = 0;
    check("t3_err_clr", err, 0);
    err_clr = 1; MIO_EN = 1;
    tick();
    wait_r("t3b_done");
    check("t3b_set_wins", err, 1);
    MIO_EN = 0; tick(); err_clr = 0;
    check("t3b_cleared", err, 0);

    // 5: MAR/MDR loads during ACCESS must not disturb the transfer
    load_mar(16'h5000);
    resp_mode = 1; ack_after = 3;
    MIO_EN = 1; R_W = 1;
    tick();
    load_mar(16'hAAAA);
    load_mdr(16'h7777);
    wait_r("t5_done");
    check("t5_addr", last_addr, 16'h5000);
    check("t5_wdata", last_wdata, 16'h1234);
    peek_mdr("t5_mdr", 16'h1234);
    MIO_EN = 0; tick();

    // 6: held MIO_EN issues exactly one transaction
    base = txn_count;
    ack_after = 1; mem_rdata = 16'h1111;
    MIO_EN = 1; R_W = 0;
    repeat (8) tick();
    check("t6_r_held", R, 1);
    check("t6_one_txn", txn_count, base + 1);
    check("t6_new_addr", last_addr, 16'hAAAA);
    MIO_EN = 0; tick();
    check("t6_r_drop", R, 0);
    MIO_EN = 1; tick();
    wait_r("t6_second");
    check("t6_two_txn", txn_count, base + 2);
    MIO_EN = 0; tick();

    // 4: async reset mid-ACCESS, late ack ignored afterwards
    resp_mode = 0;
    MIO_EN = 1; R_W = 0; GateMDR = 1;
    tick(); tick();
    check("t4_req_before", mem_req, 1);
    #2 rst_n = 0;
    #1;
    check("t4_req_rst", mem_req, 0);
    check("t4_r_rst", R, 0);
    check("t4_mdr_rst", mdr_bus_out, 0);
    MIO_EN = 0; GateMDR = 0;
    resp_mode = 2;
    tick();
    rst_n = 1;
    repeat (3) tick();
    check("t4_late_ack_req", mem_req, 0);
    check("t4_late_ack_r", R, 0);
    resp_mode = 1; ack_after = 1;
    MIO_EN = 1; R_W = 1;
    tick();
    wait_r("t4_after");
    check("t4_mar_cleared", last_addr, 16'h0);
    check("t4_mdr_cleared", last_wdata, 16'h0);
    MIO_EN = 0;
    repeat (2) tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
